cpubus_mem_responder: RTL and testbench

- Memory-side end of the 10-phase byte-serial CPU bus; the CPU-side handler is the initiator.
- Over phases 1-5 it deserializes a 32-bit address, 32-bit write data and a write flag; it then performs a word access on a local register-file RAM.
- For reads it serializes the 32-bit read word back, one byte per phase, in phases 6-9.
- Sits on the board/FPGA side of the pins, or in a self-test harness next to the CPU handler.

---
 rtl/cpubus_mem_responder.sv | 99 +++++++++
 tb/tb_cpubus_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpubus_mem_responder.sv
// Memory-side responder for the 10-phase byte-serial CPU bus: deserializes address/data,
// accesses a local word RAM and serializes read data back. Define RESP_ACCESS_COUNT_EN for acc_cnt.
module cpubus_mem_responder #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] OOR_DATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm,
  input  logic [7:0]  addr_in,
  input  logic [7:0]  wd_in,
  output logic [7:0]  rd_out,
  output logic        rd_oe,
  output logic        err
`ifdef RESP_ACCESS_COUNT_EN
  ,
  output logic [15:0] acc_cnt
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [3:0]            ph;
  logic                  in_frame;
  logic [31:2]           a;     // byte-offset bits are never decoded, so not stored
  logic [31:0]           w;
  logic [31:0]           rbuf;
  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  commit;
  logic                  is_wr;
  logic [31:0]           rd_word;

  assign idx      = a[DEPTH_LOG2+1:2];
  assign in_range = (a[31:DEPTH_LOG2+2] == '0);
  // Commit only inside a frame opened by frm, so a free-running ph never fires a phantom access.
  assign commit   = !frm && in_frame && (ph == 4'd5);
  assign is_wr    = addr_in[0];
  assign rd_word  = in_range ? mem[idx] : OOR_DATA;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= 4'd0;
      in_frame <= 1'b0;
      a        <= '0;
      w        <= '0;
      rbuf     <= '0;
      rd_out   <= 8'd0;
      rd_oe    <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (frm) begin
        ph       <= 4'd1;
        in_frame <= 1'b1;
        rd_out   <= 8'd0;
        rd_oe    <= 1'b0;
      end else begin
        ph <= (ph == 4'd9) ? 4'd0 : 4'(ph + 4'd1);
        if (ph == 4'd9) in_frame <= 1'b0;
        if (in_frame) begin
          case (ph)
            4'd1: begin a[7:2]   <= addr_in[7:2]; w[7:0]   <= wd_in; end
            4'd2: begin a[15:8]  <= addr_in;      w[15:8]  <= wd_in; end
            4'd3: begin a[23:16] <= addr_in;      w[23:16] <= wd_in; end
            4'd4: begin a[31:24] <= addr_in;      w[31:24] <= wd_in; end
            4'd5: begin
              err <= !in_range;
              if (!is_wr) begin
                rbuf   <= rd_word;
                rd_out <= rd_word[7:0];
                rd_oe  <= 1'b1;
              end
            end
            4'd6: if (rd_oe) rd_out <= rbuf[15:8];
            4'd7: if (rd_oe) rd_out <= rbuf[23:16];
            4'd8: if (rd_oe) rd_out <= rbuf[31:24];
            4'd9: begin rd_out <= 8'd0; rd_oe <= 1'b0; end
            default: ;
          endcase
        end
      end
    end
  end

  // RAM is not reset; a reset cycle simply suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && is_wr && in_range) mem[idx] <= w;
  end

`ifdef RESP_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) acc_cnt <= 16'd0;
    else if (commit && in_range && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cpubus_mem_responder.sv
// Bench for cpubus_mem_responder: frame-level reference model with a per-cycle compare
// process, directed boundary frames and randomized traffic.
module tb_cpubus_mem_responder;
  logic       clk = 1'b0;
  logic       rst, frm;
  logic [7:0] addr_in, wd_in;
  logic [7:0] rd_out;
  logic       rd_oe, err;
`ifdef RESP_ACCESS_COUNT_EN
  logic [15:0] acc_cnt;
`endif

  cpubus_mem_responder dut (
    .clk(clk), .rst(rst), .frm(frm), .addr_in(addr_in), .wd_in(wd_in),
    .rd_out(rd_out), .rd_oe(rd_oe), .err(err)
`ifdef RESP_ACCESS_COUNT_EN
    , .acc_cnt(acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;

  // Reference model: frame position, assembled words, RAM image, pending read bytes.
  int          pos = 0;
  logic [31:0] a_m = 0, w_m = 0;
  logic [31:0] ram_m [16];
  logic [7:0]  q [$];
  logic        exp_err_m = 0;
  int          cnt_m = 0;
  logic [31:0] init_vals [16];

  logic [7:0] obs_d [10];
  logic       obs_oe [10];
  logic       obs_err [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_edge();
    logic        inr;
    int          i;
    logic [31:0] d;
    exp_err_m = 1'b0;
    if (rst) begin
      pos = 0; q.delete(); a_m = 0; w_m = 0; cnt_m = 0;
    end else if (frm) begin
      pos = 1; q.delete();
    end else if (pos != 0) begin
      if (pos <= 4) begin
        a_m[8*(pos-1) +: 8] = addr_in;
        w_m[8*(pos-1) +: 8] = wd_in;
      end else if (pos == 5) begin
        inr = (a_m[31:6] == 0);
        i   = int'(a_m[5:2]);
        if (inr && cnt_m < 65535) cnt_m++;
        exp_err_m = !inr;
        if (addr_in[0]) begin
          if (inr) ram_m[i] = w_m;
        end else begin
          d = inr ? ram_m[i] : 32'h0;
          q.delete();
          q.push_back(d[7:0]);  q.push_back(d[15:8]);
          q.push_back(d[23:16]); q.push_back(d[31:24]);
        end
      end else if (q.size() != 0) begin
        void'(q.pop_front());
      end
      pos = (pos == 9) ? 0 : pos + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_out", {24'h0, rd_out}, (q.size() != 0) ? {24'h0, q[0]} : 32'h0);
      chk("rd_oe", {31'h0, rd_oe}, {31'h0, q.size() != 0});
      chk("err", {31'h0, err}, {31'h0, exp_err_m});
`ifdef RESP_ACCESS_COUNT_EN
      chk("acc_cnt", {16'h0, acc_cnt}, cnt_m);
`endif
    end
  end

  task automatic run_frame(input logic [31:0] ad, input logic [31:0] wd, input bit wr, input int len);
    for (int p = 0; p < len; p++) begin
      frm = (p == 0);
      if (p >= 1 && p <= 4) begin
        addr_in = ad[8*(p-1) +: 8];
        wd_in   = wd[8*(p-1) +: 8];
      end else if (p == 5) begin
        addr_in = {7'($urandom), wr};
        wd_in   = 8'($urandom);
      end else begin
        addr_in = 8'($urandom);
        wd_in   = 8'($urandom);
      end
      tick();
      obs_d[p] = rd_out; obs_oe[p] = rd_oe; obs_err[p] = err;
    end
    frm = 1'b0;
  endtask

  task automatic idle(input int n);
    frm = 1'b0;
    for (int k = 0; k < n; k++) begin
      addr_in = 8'($urandom);
      wd_in   = 8'($urandom);
      tick();
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1; frm = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          nerr;
    logic [31:0] ad;
    rst = 1'b1; frm = 1'b0; addr_in = 8'h0; wd_in = 8'h0;
    tick();
    chk_en = 1;
    tick(); tick();
    chk("rst_rd_out", {24'h0, rd_out}, 32'h0);
    chk("rst_rd_oe", {31'h0, rd_oe}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    idle(25);

    // Fill every word so later reads are defined.
    for (int i = 0; i < 16; i++) begin
      init_vals[i] = $urandom;
      run_frame(i * 4, init_vals[i], 1'b1, 10);
    end

    // Write then read 0x8.
    run_frame(32'h0000_0008, 32'hDEADBEEF, 1'b1, 10);
    chk("model_ram2", ram_m[2], 32'hDEADBEEF);
    run_frame(32'h0000_0008, 32'h0, 1'b0, 10);
    chk("rd_b0", {24'h0, obs_d[5]}, 32'hEF);
    chk("rd_b1", {24'h0, obs_d[6]}, 32'hBE);
    chk("rd_b2", {24'h0, obs_d[7]}, 32'hAD);
    chk("rd_b3", {24'h0, obs_d[8]}, 32'hDE);
    chk("oe_ph5", {31'h0, obs_oe[4]}, 32'h0);
    chk("oe_ph6", {31'h0, obs_oe[5]}, 32'h1);
    chk("oe_ph0", {31'h0, obs_oe[9]}, 32'h0);
    chk("rd_err", {31'h0, obs_err[5]}, 32'h0);

    // Out-of-range read: zero data, one err pulse in phase 6.
    run_frame(32'h0000_0100, 32'h0, 1'b0, 10);
    nerr = 0;
    for (int p = 0; p < 10; p++) nerr += int'(obs_err[p]);
    chk("oor_err_ph6", {31'h0, obs_err[5]}, 32'h1);
    chk("oor_err_cnt", nerr, 1);
    chk("oor_data", {obs_d[8], obs_d[7], obs_d[6], obs_d[5]}, 32'h0);
    run_frame(32'h0000_0100, 32'h1234_5678, 1'b1, 10);
    for (int i = 0; i < 16; i++) run_frame(i * 4, 32'h0, 1'b0, 10);

    // Write aborted at phase 3 leaves the word alone.
    run_frame(32'h0000_000C, 32'hCAFE_F00D, 1'b1, 3);
    run_frame(32'h0000_000C, 32'h0, 1'b0, 10);
    chk("abort_wr", {obs_d[8], obs_d[7], obs_d[6], obs_d[5]}, init_vals[3]);

    // Read aborted at phase 7, then a clean read.
    run_frame(32'h0000_0008, 32'h0, 1'b0, 7);
    run_frame(32'h0000_0008, 32'h0, 1'b0, 10);
    chk("abort_rd_oe", {31'h0, obs_oe[0]}, 32'h0);
    chk("abort_rd_out", {24'h0, obs_d[0]}, 32'h0);
    chk("reread", {obs_d[8], obs_d[7], obs_d[6], obs_d[5]}, 32'hDEADBEEF);

    // All-ones address is out of range.
    run_frame(32'hFFFF_FFFF, 32'h0, 1'b0, 10);
    chk("ffff_err", {31'h0, obs_err[5]}, 32'h1);

    // Reset mid-frame drops the pending write.
    run_frame(32'h0000_0004, 32'h5555_AAAA, 1'b1, 4);
    reset_pulse();
    idle(3);
    run_frame(32'h0000_0004, 32'h0, 1'b0, 10);
    chk("rst_drop_wr", {obs_d[8], obs_d[7], obs_d[6], obs_d[5]}, init_vals[1]);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       ad = $urandom;
        1:       ad = 32'hFFFF_FFFF;
        default: ad = {26'h0, 4'($urandom), 2'($urandom)};
      endcase
      if ($urandom_range(0, 29) == 0) begin
        run_frame(ad, $urandom, 1'($urandom), $urandom_range(1, 9));
        reset_pulse();
      end else begin
        run_frame(ad, $urandom, 1'($urandom),
                  ($urandom_range(0, 6) == 0) ? $urandom_range(1, 9) : 10);
      end
      idle($urandom_range(0, 3));
    end
    idle(12);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
